// File: rtl/mux16_serializer_if.sv
// Handshake and mux-drive bundle between the word source, the serializer and the 16:1 mux.
// master = serializer side, slave = source/consumer side.
interface mux16_serializer_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic [15:0] word;
  logic [3:0]  sel;
  logic        bit_valid;
  logic        bit_ready;
  logic        bit_first;
  logic        bit_last;

  modport master (
    input  in_data, in_valid, abort, bit_ready,
    output in_ready, word, sel, bit_valid, bit_first, bit_last
  );

  modport slave (
    output in_data, in_valid, abort, bit_ready,
    input  in_ready, word, sel, bit_valid, bit_first, bit_last
  );
endinterface

// File: rtl/mux16_serializer.sv
// Sequencer feeding a 16:1 mux: latches a word, then walks the select through all
// 16 positions under valid/ready back-pressure, turning the mux into a serializer.
module mux16_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux16_serializer_if.master   bus
);

  localparam logic [3:0] START = MSB_FIRST ? 4'd15 : 4'd0;
  localparam logic [3:0] END   = MSB_FIRST ? 4'd0  : 4'd15;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic [15:0] word_q, word_nxt;
  logic [3:0]  sel_q, sel_nxt;
  logic        vld_q, vld_nxt;
  logic        first_q, first_nxt;
  logic        last_q, last_nxt;

  logic        in_ready;
  logic        accept;
  logic        at_end;
  logic [3:0]  sel_step;

  assign at_end   = (sel_q == END);
  assign sel_step = MSB_FIRST ? (sel_q - 4'd1) : (sel_q + 4'd1);

  // Ready on the last consumed beat lets a new word reload with no bubble.
  assign in_ready = !bus.abort &&
                    ((state == IDLE) || ((state == SHIFT) && at_end && bus.bit_ready));
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      word_q  <= 16'h0000;
      sel_q   <= START;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      word_q  <= word_nxt;
      sel_q   <= sel_nxt;
      vld_q   <= vld_nxt;
      first_q <= first_nxt;
      last_q  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = word_q;
    sel_nxt   = sel_q;
    vld_nxt   = vld_q;
    first_nxt = first_q;
    last_nxt  = last_q;

    if (bus.abort) begin
      // Flush: word stays on the mux inputs, everything else returns to idle.
      state_nxt = IDLE;
      sel_nxt   = START;
      vld_nxt   = 1'b0;
      first_nxt = 1'b0;
      last_nxt  = 1'b0;
    end else if (accept) begin
      state_nxt = SHIFT;
      word_nxt  = bus.in_data;
      sel_nxt   = START;
      vld_nxt   = 1'b1;
      first_nxt = 1'b1;
      last_nxt  = 1'b0;
    end else if ((state == SHIFT) && bus.bit_ready) begin
      if (!at_end) begin
        sel_nxt   = sel_step;
        first_nxt = 1'b0;
        last_nxt  = (sel_step == END);
      end else begin
        state_nxt = IDLE;
        sel_nxt   = START;
        vld_nxt   = 1'b0;
        first_nxt = 1'b0;
        last_nxt  = 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.word      = word_q;
  assign bus.sel       = sel_q;
  assign bus.bit_valid = vld_q;
  assign bus.bit_first = first_q;
  assign bus.bit_last  = last_q;

endmodule

// File: tb/tb_mux16_serializer.sv
// Directed bench: LSB-first and MSB-first serializers side by side, checking beats,
// flags, back-to-back reload, stall, abort and asynchronous reset.
module tb_mux16_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux16_serializer_if a ();
  mux16_serializer_if b ();

  mux16_serializer #(.MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst_n(rst_n), .bus(a));
  mux16_serializer #(.MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst_n(rst_n), .bus(b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Full LSB-first word with bit_ready held high, then an idle check.
  task automatic send_a(input logic [15:0] d, input string tag);
    @(negedge clk);
    a.in_data  = d;
    a.in_valid = 1'b1;
    a.bit_ready = 1'b1;
    #1 check({tag, " in_ready idle"}, 32'(a.in_ready), 32'd1);
    @(posedge clk);
    #1 a.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check({tag, " valid"}, 32'(a.bit_valid), 32'd1);
      check({tag, " sel"},   32'(a.sel),       32'(i));
      check({tag, " bit"},   32'(a.word[a.sel]), 32'(d[i]));
      check({tag, " first"}, 32'(a.bit_first), 32'(i == 0));
      check({tag, " last"},  32'(a.bit_last),  32'(i == 15));
      check({tag, " in_ready"}, 32'(a.in_ready), 32'(i == 15));
    end
    @(negedge clk);
    check({tag, " done valid"}, 32'(a.bit_valid), 32'd0);
    check({tag, " done in_ready"}, 32'(a.in_ready), 32'd1);
    check({tag, " done sel"}, 32'(a.sel), 32'd0);
  endtask

  initial begin
    int cyc;
    int hold;
    bit stalled;
    bit found;
    logic [15:0] exp_d;

    a.in_data = '0; a.in_valid = 1'b0; a.abort = 1'b0; a.bit_ready = 1'b1;
    b.in_data = '0; b.in_valid = 1'b0; b.abort = 1'b0; b.bit_ready = 1'b1;

    // Reset values
    #12;
    check("rst sel lsb", 32'(a.sel), 32'd0);
    check("rst sel msb", 32'(b.sel), 32'd15);
    check("rst word", 32'(a.word), 32'h0);
    check("rst flags", {29'd0, a.bit_valid, a.bit_first, a.bit_last}, 32'd0);
    check("rst in_ready", 32'(a.in_ready), 32'd1);
    #10 rst_n = 1'b1;

    send_a(16'hA5C3, "a5c3");

    // Back-to-back FFFF then 0000, in_valid kept high across the reload
    @(negedge clk);
    a.in_data = 16'hFFFF; a.in_valid = 1'b1;
    @(posedge clk);
    #1 a.in_data = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      exp_d = (i < 16) ? 16'hFFFF : 16'h0000;
      @(negedge clk);
      check("b2b valid", 32'(a.bit_valid), 32'd1);
      check("b2b sel", 32'(a.sel), 32'(i % 16));
      check("b2b bit", 32'(a.word[a.sel]), 32'(exp_d[i % 16]));
      check("b2b first", 32'(a.bit_first), 32'((i % 16) == 0));
      check("b2b in_ready", 32'(a.in_ready), 32'((i % 16) == 15));
      if (i == 15) begin
        @(posedge clk);
        #1 a.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b idle", 32'(a.bit_valid), 32'd0);

    // Stall at sel=7 for 5 cycles on word 0080
    @(negedge clk);
    a.in_data = 16'h0080; a.in_valid = 1'b1;
    @(posedge clk);
    #1 a.in_valid = 1'b0;
    cyc = 0; hold = 0; stalled = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!a.bit_valid) break;
      cyc++;
      check("stall bit", 32'(a.word[a.sel]), 32'(a.sel == 4'd7));
      if (stalled && hold < 5) begin
        hold++;
        check("stall sel", 32'(a.sel), 32'd7);
        check("stall word", 32'(a.word), 32'h0080);
        if (hold == 5) a.bit_ready = 1'b1;
      end else if (!stalled && a.sel == 4'd7) begin
        stalled = 1'b1;
        a.bit_ready = 1'b0;
      end
    end
    check("stall hold count", 32'(hold), 32'd5);
    check("stall length", 32'(cyc), 32'd21);
    a.bit_ready = 1'b1;

    // MSB-first 8001
    @(negedge clk);
    b.in_data = 16'h8001; b.in_valid = 1'b1;
    @(posedge clk);
    #1 b.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("msb valid", 32'(b.bit_valid), 32'd1);
      check("msb sel", 32'(b.sel), 32'(15 - i));
      check("msb bit", 32'(b.word[b.sel]), 32'(i == 0 || i == 15));
      check("msb first", 32'(b.bit_first), 32'(i == 0));
      check("msb last", 32'(b.bit_last), 32'(i == 15));
    end
    @(negedge clk);
    check("msb idle", 32'(b.bit_valid), 32'd0);
    check("msb idle sel", 32'(b.sel), 32'd15);

    // Abort at sel=9 with a competing word offered
    @(negedge clk);
    a.in_data = 16'h1234; a.in_valid = 1'b1;
    @(posedge clk);
    #1 a.in_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a.sel == 4'd9 && a.bit_valid) begin found = 1'b1; break; end
    end
    check("abort reach sel9", 32'(found), 32'd1);
    a.abort = 1'b1; a.in_valid = 1'b1; a.in_data = 16'hFFFF;
    #1 check("abort in_ready", 32'(a.in_ready), 32'd0);
    @(posedge clk);
    #1 a.abort = 1'b0; a.in_valid = 1'b0;
    @(negedge clk);
    check("abort valid", 32'(a.bit_valid), 32'd0);
    check("abort sel", 32'(a.sel), 32'd0);
    check("abort flags", {30'd0, a.bit_first, a.bit_last}, 32'd0);
    check("abort word kept", 32'(a.word), 32'h1234);
    check("abort in_ready", 32'(a.in_ready), 32'd1);
    send_a(16'h5A3C, "post-abort");

    // Asynchronous reset pulse at sel=4
    @(negedge clk);
    a.in_data = 16'hBEEF; a.in_valid = 1'b1;
    @(posedge clk);
    #1 a.in_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a.sel == 4'd4 && a.bit_valid) begin found = 1'b1; break; end
    end
    check("rst reach sel4", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst valid", 32'(a.bit_valid), 32'd0);
    check("arst sel", 32'(a.sel), 32'd0);
    check("arst word", 32'(a.word), 32'h0);
    check("arst in_ready", 32'(a.in_ready), 32'd1);
    check("arst sel msb", 32'(b.sel), 32'd15);
    #9 rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a.bit_valid) cyc++;
    end
    check("arst no beats", 32'(cyc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
